wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_wb_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter sharing one slave: round-robin on ties, bus
// tenure held while the owner's cyc stays high, stall timeout converts to err.
module wb_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_arst,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [3:0]  i_m0_sel,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    output logic [31:0] o_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [3:0]  i_m1_sel,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    output logic [31:0] o_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [3:0]  o_s_sel,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    input  logic [31:0] i_s_dat,
    input  logic        i_s_ack,
    output logic [1:0]  o_grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // The counter holds completed stall cycles, so the timeout fires on the
    // cycle in which it still reads TIMEOUT-1.
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 32'd1);

    state_t      state_r;
    logic        owner_r;
    logic        last_owner_r;
    logic [15:0] stall_cnt_r;

    logic        own_cyc_s;
    logic        own_stb_s;
    logic        own_we_s;
    logic [3:0]  own_sel_s;
    logic [31:0] own_adr_s;
    logic [31:0] own_dat_s;
    logic        stall_s;
    logic        timeout_s;
    logic        ack_s;

    // Select the current owner's request fields
    always_comb begin
        if (owner_r) begin
            own_cyc_s = i_m1_cyc;
            own_stb_s = i_m1_stb;
            own_we_s  = i_m1_we;
            own_sel_s = i_m1_sel;
            own_adr_s = i_m1_adr;
            own_dat_s = i_m1_dat;
        end else begin
            own_cyc_s = i_m0_cyc;
            own_stb_s = i_m0_stb;
            own_we_s  = i_m0_we;
            own_sel_s = i_m0_sel;
            own_adr_s = i_m0_adr;
            own_dat_s = i_m0_dat;
        end
    end

    // Stall and timeout detection; a late ack always beats the timeout
    always_comb begin
        stall_s   = 1'b0;
        timeout_s = 1'b0;
        ack_s     = 1'b0;
        if (state_r == ST_OWN) begin
            stall_s   = own_stb_s & ~i_s_ack;
            timeout_s = stall_s & (stall_cnt_r == STALL_LAST);
            ack_s     = i_s_ack;
        end else begin
            stall_s   = 1'b0;
            timeout_s = 1'b0;
            ack_s     = 1'b0;
        end
    end

    // Slave-side bus and master responses
    always_comb begin
        o_s_cyc  = 1'b0;
        o_s_stb  = 1'b0;
        o_s_we   = 1'b0;
        o_s_sel  = 4'h0;
        o_s_adr  = 32'h0;
        o_s_dat  = 32'h0;
        o_m0_ack = 1'b0;
        o_m0_err = 1'b0;
        o_m1_ack = 1'b0;
        o_m1_err = 1'b0;
        o_grant  = 2'b00;
        case (state_r)
            ST_OWN: begin
                o_s_cyc  = own_cyc_s;
                o_s_stb  = own_stb_s;
                o_s_we   = own_we_s;
                o_s_sel  = own_sel_s;
                o_s_adr  = own_adr_s;
                o_s_dat  = own_dat_s;
                o_m0_ack = ack_s & ~owner_r;
                o_m1_ack = ack_s & owner_r;
                o_m0_err = timeout_s & ~owner_r;
                o_m1_err = timeout_s & owner_r;
                o_grant  = owner_r ? 2'b10 : 2'b01;
            end
            ST_ERR: begin
                o_grant = owner_r ? 2'b10 : 2'b01;
            end
            default: begin
                o_grant = 2'b00;
            end
        endcase
    end

    assign o_m0_dat = i_s_dat;
    assign o_m1_dat = i_s_dat;

    // Arbitration FSM with owner history and stall counter
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            stall_cnt_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stall_cnt_r <= 16'd0;
                    if (i_m0_cyc && i_m1_cyc) begin
                        owner_r <= ~last_owner_r;
                        state_r <= ST_OWN;
                    end else if (i_m0_cyc) begin
                        owner_r <= 1'b0;
                        state_r <= ST_OWN;
                    end else if (i_m1_cyc) begin
                        owner_r <= 1'b1;
                        state_r <= ST_OWN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_OWN: begin
                    if (!own_cyc_s) begin
                        state_r      <= ST_IDLE;
                        last_owner_r <= owner_r;
                        stall_cnt_r  <= 16'd0;
                    end else if (timeout_s) begin
                        state_r     <= ST_ERR;
                        stall_cnt_r <= 16'd0;
                    end else if (stall_s) begin
                        stall_cnt_r <= stall_cnt_r + 16'd1;
                    end else begin
                        stall_cnt_r <= 16'd0;
                    end
                end
                ST_ERR: begin
                    stall_cnt_r <= 16'd0;
                    if (!own_cyc_s) begin
                        state_r      <= ST_IDLE;
                        last_owner_r <= owner_r;
                    end else begin
                        state_r <= ST_ERR;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    stall_cnt_r <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic checked
// against a tenure-level model of the arbitration rules.
module tb_wb_arbiter;

    localparam int TO = 8;

    logic        i_clk, i_arst;
    logic        i_m0_cyc, i_m0_stb, i_m0_we;
    logic [3:0]  i_m0_sel;
    logic [31:0] i_m0_adr, i_m0_dat;
    logic [31:0] o_m0_dat;
    logic        o_m0_ack, o_m0_err;
    logic        i_m1_cyc, i_m1_stb, i_m1_we;
    logic [3:0]  i_m1_sel;
    logic [31:0] i_m1_adr, i_m1_dat;
    logic [31:0] o_m1_dat;
    logic        o_m1_ack, o_m1_err;
    logic        o_s_cyc, o_s_stb, o_s_we;
    logic [3:0]  o_s_sel;
    logic [31:0] o_s_adr, o_s_dat;
    logic [31:0] i_s_dat;
    logic        i_s_ack;
    logic [1:0]  o_grant;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: who holds the bus (-1 = nobody), whether the tenure has errored,
    // who held it last, and how many stall cycles the current transfer has seen.
    int  m_owner;
    bit  m_errored;
    int  m_last;
    int  m_stall;

    logic [31:0] rd_vals [3];

    wb_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
        .i_m0_sel(i_m0_sel), .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat),
        .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
        .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
        .i_m1_sel(i_m1_sel), .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat),
        .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
        .o_s_sel(o_s_sel), .o_s_adr(o_s_adr), .o_s_dat(o_s_dat),
        .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .o_grant(o_grant)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_errored = 1'b0;
        m_last    = 1;
        m_stall   = 0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_cyc, e_stb, e_we, e_sel, e_adr, e_dat;
        logic [31:0] e_ack0, e_ack1, e_err0, e_err1, e_grant;
        bit timed;
        e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_adr = 0; e_dat = 0;
        e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_grant = 0;
        if (m_owner >= 0) e_grant = (m_owner == 0) ? 32'd1 : 32'd2;
        if (m_owner >= 0 && !m_errored) begin
            if (m_owner == 0) begin
                e_cyc = 32'(i_m0_cyc); e_stb = 32'(i_m0_stb); e_we = 32'(i_m0_we);
                e_sel = 32'(i_m0_sel); e_adr = i_m0_adr; e_dat = i_m0_dat;
            end else begin
                e_cyc = 32'(i_m1_cyc); e_stb = 32'(i_m1_stb); e_we = 32'(i_m1_we);
                e_sel = 32'(i_m1_sel); e_adr = i_m1_adr; e_dat = i_m1_dat;
            end
            timed = (e_stb != 0) && !i_s_ack && (m_stall + 1 == TO);
            if (m_owner == 0) begin
                e_ack0 = 32'(i_s_ack); e_err0 = 32'(timed);
            end else begin
                e_ack1 = 32'(i_s_ack); e_err1 = 32'(timed);
            end
        end
        chk({tag, ".s_cyc"},  32'(o_s_cyc),  e_cyc);
        chk({tag, ".s_stb"},  32'(o_s_stb),  e_stb);
        chk({tag, ".s_we"},   32'(o_s_we),   e_we);
        chk({tag, ".s_sel"},  32'(o_s_sel),  e_sel);
        chk({tag, ".s_adr"},  o_s_adr,       e_adr);
        chk({tag, ".s_dat"},  o_s_dat,       e_dat);
        chk({tag, ".m0_ack"}, 32'(o_m0_ack), e_ack0);
        chk({tag, ".m1_ack"}, 32'(o_m1_ack), e_ack1);
        chk({tag, ".m0_err"}, 32'(o_m0_err), e_err0);
        chk({tag, ".m1_err"}, 32'(o_m1_err), e_err1);
        chk({tag, ".grant"},  32'(o_grant),  e_grant);
        chk({tag, ".m0_dat"}, o_m0_dat,      i_s_dat);
        chk({tag, ".m1_dat"}, o_m1_dat,      i_s_dat);
    endtask

    // Apply the arbitration rules for one rising edge, using the inputs held before it.
    task automatic model_edge();
        bit c, s;
        if (m_owner < 0) begin
            m_stall = 0;
            if (i_m0_cyc && i_m1_cyc) m_owner = 1 - m_last;
            else if (i_m0_cyc)        m_owner = 0;
            else if (i_m1_cyc)        m_owner = 1;
        end else begin
            c = (m_owner == 0) ? i_m0_cyc : i_m1_cyc;
            s = (m_owner == 0) ? i_m0_stb : i_m1_stb;
            if (!c) begin
                m_last    = m_owner;
                m_owner   = -1;
                m_errored = 1'b0;
                m_stall   = 0;
            end else if (!m_errored && s && !i_s_ack) begin
                m_stall++;
                if (m_stall == TO) begin
                    m_errored = 1'b1;
                    m_stall   = 0;
                end
            end else begin
                m_stall = 0;
            end
        end
    endtask

    task automatic settle(input string tag);
        #4;
        check_all(tag);
    endtask

    task automatic edge_step();
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic set_m0(input bit cyc, input bit stb, input bit we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
        i_m0_cyc = cyc; i_m0_stb = stb; i_m0_we = we;
        i_m0_sel = sel; i_m0_adr = adr; i_m0_dat = dat;
    endtask

    task automatic set_m1(input bit cyc, input bit stb, input bit we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
        i_m1_cyc = cyc; i_m1_stb = stb; i_m1_we = we;
        i_m1_sel = sel; i_m1_adr = adr; i_m1_dat = dat;
    endtask

    task automatic reset_pulse();
        #2;
        i_arst = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        chk("rst.grant", 32'(o_grant), 32'd0);
        @(posedge i_clk);
        #1;
        check_all("rst_hold");
        i_arst = 1'b0;
    endtask

    initial begin
        bit c0, c1;
        int ack_div;
        rd_vals[0] = 32'h1111_1111;
        rd_vals[1] = 32'h1234_5678;
        rd_vals[2] = 32'h0000_03F8;
        i_arst = 1'b1;
        set_m0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        i_s_dat = 32'hA5A5_0001;
        i_s_ack = 1'b0;
        model_reset();
        @(posedge i_clk);
        #1;
        check_all("por");
        @(posedge i_clk);
        #1;
        i_arst = 1'b0;

        // Single master write, slave acks one cycle after stb
        set_m0(1'b1, 1'b1, 1'b1, 4'hF, 32'h500, 32'd21);
        settle("r28c0");
        chk("r28.cyc_latency", 32'(o_s_cyc), 32'd0);
        edge_step();
        settle("r28c1");
        chk("r28.cyc_up", 32'(o_s_cyc), 32'd1);
        chk("r28.grant", 32'(o_grant), 32'd1);
        edge_step();
        i_s_ack = 1'b1;
        settle("r28c2");
        chk("r28.m0_ack", 32'(o_m0_ack), 32'd1);
        chk("r28.m1_ack", 32'(o_m1_ack), 32'd0);
        chk("r28.adr", o_s_adr, 32'h500);
        chk("r28.dat", o_s_dat, 32'd21);
        edge_step();
        i_s_ack = 1'b0;
        set_m0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle("r28c3");
        chk("r28.ack_once", 32'(o_m0_ack), 32'd0);
        edge_step();
        settle("r28c4");
        edge_step();

        // Round-robin on ties, starting fresh from reset
        reset_pulse();
        set_m0(1'b1, 1'b0, 1'b0, 4'h1, 32'h10, 32'h0);
        set_m1(1'b1, 1'b0, 1'b0, 4'h2, 32'h20, 32'h0);
        settle("r29c0");
        edge_step();
        settle("r29c1");
        chk("r29.first_tie", 32'(o_grant), 32'd1);
        i_m0_cyc = 1'b0;
        settle("r29c2");
        edge_step();
        settle("r29c3");
        chk("r29.idle_gap", 32'(o_grant), 32'd0);
        edge_step();
        settle("r29c4");
        chk("r29.m1_next", 32'(o_grant), 32'd2);
        i_m1_cyc = 1'b0;
        settle("r29c5");
        edge_step();
        i_m0_cyc = 1'b1;
        i_m1_cyc = 1'b1;
        settle("r29c6");
        edge_step();
        settle("r29c7");
        chk("r29.second_tie", 32'(o_grant), 32'd1);
        set_m0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle("r29c8");
        edge_step();

        // m1 holds the bus through three reads while m0 waits
        set_m1(1'b1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        settle("r30c0");
        edge_step();
        set_m0(1'b1, 1'b1, 1'b1, 4'h3, 32'h80, 32'hBEEF);
        for (int k = 0; k < 3; k++) begin
            i_s_ack = 1'b1;
            i_s_dat = rd_vals[k];
            settle("r30rd");
            chk("r30.m1_ack", 32'(o_m1_ack), 32'd1);
            chk("r30.m1_dat", o_m1_dat, rd_vals[k]);
            chk("r30.m0_ack", 32'(o_m0_ack), 32'd0);
            chk("r30.grant", 32'(o_grant), 32'd2);
            edge_step();
        end
        i_s_ack = 1'b0;
        set_m1(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle("r30c4");
        edge_step();
        settle("r30c5");
        chk("r30.gap", 32'(o_grant), 32'd0);
        edge_step();
        settle("r30c6");
        chk("r30.m0_after", 32'(o_grant), 32'd1);
        set_m0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle("r30c7");
        edge_step();

        // Stall timeout: err on the TO-th stall cycle, then bus released
        set_m0(1'b1, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
        settle("r31c0");
        edge_step();
        for (int k = 1; k <= TO; k++) begin
            settle("r31st");
            chk("r31.err", 32'(o_m0_err), 32'(k == TO));
            chk("r31.ack", 32'(o_m0_ack), 32'd0);
            edge_step();
        end
        settle("r31err");
        chk("r31.cyc_low", 32'(o_s_cyc), 32'd0);
        chk("r31.err_once", 32'(o_m0_err), 32'd0);
        chk("r31.grant_kept", 32'(o_grant), 32'd1);
        i_s_ack = 1'b1;
        edge_step();
        settle("r31discard");
        chk("r31.ack_dropped", 32'(o_m0_ack), 32'd0);
        i_s_ack = 1'b0;
        set_m0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle("r31drop");
        edge_step();
        settle("r31idle");
        chk("r31.idle", 32'(o_grant), 32'd0);

        // Ack on the very cycle that would have timed out wins
        set_m0(1'b1, 1'b1, 1'b0, 4'hF, 32'h604, 32'h0);
        settle("r32c0");
        edge_step();
        for (int k = 1; k <= TO; k++) begin
            i_s_ack = (k == TO);
            settle("r32st");
            chk("r32.ack", 32'(o_m0_ack), 32'(k == TO));
            chk("r32.err", 32'(o_m0_err), 32'd0);
            edge_step();
        end
        i_s_ack = 1'b0;
        settle("r32after");
        chk("r32.still_own", 32'(o_s_cyc), 32'd1);
        set_m0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        edge_step();
        settle("r32idle");
        edge_step();

        // Reset in the middle of an m1 read
        set_m1(1'b1, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
        settle("r33c0");
        edge_step();
        settle("r33c1");
        chk("r33.m1_owns", 32'(o_grant), 32'd2);
        edge_step();
        i_s_ack = 1'b1;
        i_s_dat = 32'hDEAD_0033;
        reset_pulse();
        chk("r33.no_ack", 32'(o_m1_ack), 32'd0);
        chk("r33.dat_follow", o_m1_dat, 32'hDEAD_0033);
        i_s_ack = 1'b0;
        set_m0(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle("r33c2");
        edge_step();
        settle("r33c3");
        chk("r33.tie_m0", 32'(o_grant), 32'd1);
        set_m0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle("r33c4");
        edge_step();

        // Randomized traffic against the model
        c0 = 1'b0;
        c1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) c0 = ~c0;
            if ($urandom_range(0, 7) == 0) c1 = ~c1;
            set_m0(c0, c0 & ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                   $urandom, $urandom);
            set_m1(c1, c1 & ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                   $urandom, $urandom);
            ack_div = ((c / 200) % 2 == 1) ? 15 : 1;
            i_s_ack = ($urandom_range(0, ack_div) == 0);
            i_s_dat = $urandom;
            settle("rnd");
            edge_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
